// File: rtl/pe_ws_dbuf.sv
// pe_ws_dbuf: weight-stationary MAC processing element for a systolic array.
// Activations flow east, partial sums and weights flow south. A shadow weight
// register is filled over the daisy-chained weight path while the active weight
// keeps computing. A swap pulse then commits the shadow weight, and that pulse
// also propagates south as a wavefront.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   data_in/data_vld_in   activation and valid from west
//   data_out/data_vld_out registered activation and valid to east
//   acc_in                partial sum from north
//   acc_out/acc_vld_out   registered partial sum and valid to south
//   wt_in/wt_ld_in        weight chain value and strobe from north
//   wt_out/wt_ld_out      registered weight chain value and strobe to south
//   swap_in/swap_out      commit pulse from north, registered copy to south
//   wt_ready              active weight holds a committed value
//   ovf/ovf_clr           sticky accumulator overflow flag, synchronous clear
module pe_ws_dbuf #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int SIGNED = 1,
    parameter int SAT    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_vld_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_vld_out,
    input  logic [ACC_W-1:0]  acc_in,
    output logic [ACC_W-1:0]  acc_out,
    output logic              acc_vld_out,
    input  logic [DATA_W-1:0] wt_in,
    input  logic              wt_ld_in,
    output logic [DATA_W-1:0] wt_out,
    output logic              wt_ld_out,
    input  logic              swap_in,
    output logic              swap_out,
    output logic              wt_ready,
    output logic              ovf,
    input  logic              ovf_clr
);

    localparam int PW        = 2 * DATA_W;
    localparam bit IS_SIGNED = (SIGNED != 0);
    localparam bit IS_SAT    = (SAT != 0);

    typedef enum logic {
        EMPTY  = 1'b0,
        ACTIVE = 1'b1
    } wstate_t;

    wstate_t           state_q, state_d;
    logic [DATA_W-1:0] shadow_q;
    logic [DATA_W-1:0] active_q;
    logic              shadow_full_q;

    logic [PW-1:0]     mul_a, mul_b, prod;
    logic [ACC_W-1:0]  prod_ext;
    logic [ACC_W:0]    sum;
    logic              sum_ovf;
    logic [ACC_W-1:0]  mac_res;

    // Operands are extended to the full product width first, so the low PW
    // bits of an unsigned multiply give the correct signed or unsigned product.
    // active_q stays 0 until the first commit, so an EMPTY cell passes acc_in
    // through unchanged.
    always_comb begin
        mul_a    = {{DATA_W{IS_SIGNED & data_in[DATA_W-1]}}, data_in};
        mul_b    = {{DATA_W{IS_SIGNED & active_q[DATA_W-1]}}, active_q};
        prod     = mul_a * mul_b;
        prod_ext = {{(ACC_W-PW){IS_SIGNED & prod[PW-1]}}, prod};
        sum      = {IS_SIGNED & acc_in[ACC_W-1], acc_in}
                 + {IS_SIGNED & prod_ext[ACC_W-1], prod_ext};
        // Signed: the guard bit and the result MSB disagree. Unsigned: carry out.
        sum_ovf  = IS_SIGNED ? (sum[ACC_W] ^ sum[ACC_W-1]) : sum[ACC_W];
        mac_res  = sum[ACC_W-1:0];
        if (IS_SAT && sum_ovf) begin
            if (!IS_SIGNED) begin
                mac_res = '1;
            end else if (sum[ACC_W]) begin
                mac_res = {1'b1, {(ACC_W-1){1'b0}}};
            end else begin
                mac_res = {1'b0, {(ACC_W-1){1'b1}}};
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (swap_in && shadow_full_q) begin
            state_d = ACTIVE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    assign wt_ready = (state_q == ACTIVE);

    // A commit and a new load can share a cycle. The old shadow moves to
    // active, and the incoming beat refills the shadow so it stays full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
            active_q      <= '0;
        end else begin
            if (swap_in && shadow_full_q) begin
                active_q <= shadow_q;
            end
            if (wt_ld_in) begin
                shadow_q      <= wt_in;
                shadow_full_q <= 1'b1;
            end else if (swap_in && shadow_full_q) begin
                shadow_full_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wt_out    <= '0;
            wt_ld_out <= 1'b0;
            swap_out  <= 1'b0;
        end else begin
            wt_out    <= wt_in;
            wt_ld_out <= wt_ld_in;
            swap_out  <= swap_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out     <= '0;
            data_vld_out <= 1'b0;
            acc_out      <= '0;
            acc_vld_out  <= 1'b0;
        end else begin
            data_vld_out <= data_vld_in;
            acc_vld_out  <= data_vld_in;
            if (data_vld_in) begin
                data_out <= data_in;
                acc_out  <= mac_res;
            end
        end
    end

    // A fresh overflow takes priority over a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (data_vld_in && sum_ovf) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pe_ws_dbuf.sv
module tb_pe_ws_dbuf;

    logic        clk;
    logic        rst_n;
    logic [7:0]  d;
    logic        dv;
    logic [31:0] acc;
    logic [7:0]  wt;
    logic        ld;
    logic        sw;
    logic        clr;

    logic [7:0]  dout_s, dout_w, wto_s, wto_w;
    logic        dvo_s, dvo_w, avo_s, avo_w, ldo_s, ldo_w, swo_s, swo_w;
    logic        rdy_s, rdy_w, ovf_s, ovf_w;
    logic [31:0] acco_s, acco_w;

    int checks   = 0;
    int failures = 0;

    pe_ws_dbuf #(.DATA_W(8), .ACC_W(32), .SIGNED(1), .SAT(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .data_in(d), .data_vld_in(dv),
        .data_out(dout_s), .data_vld_out(dvo_s), .acc_in(acc),
        .acc_out(acco_s), .acc_vld_out(avo_s), .wt_in(wt), .wt_ld_in(ld),
        .wt_out(wto_s), .wt_ld_out(ldo_s), .swap_in(sw), .swap_out(swo_s),
        .wt_ready(rdy_s), .ovf(ovf_s), .ovf_clr(clr)
    );

    pe_ws_dbuf #(.DATA_W(8), .ACC_W(32), .SIGNED(1), .SAT(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .data_in(d), .data_vld_in(dv),
        .data_out(dout_w), .data_vld_out(dvo_w), .acc_in(acc),
        .acc_out(acco_w), .acc_vld_out(avo_w), .wt_in(wt), .wt_ld_in(ld),
        .wt_out(wto_w), .wt_ld_out(ldo_w), .swap_in(sw), .swap_out(swo_w),
        .wt_ready(rdy_w), .ovf(ovf_w), .ovf_clr(clr)
    );

    // Four-cell column sharing the weight chain.
    logic [7:0]  col_wt;
    logic        col_ld, col_sw, col_dv;
    logic [7:0]  col_d;
    logic [7:0]  c_wt [0:4];
    logic        c_ld [0:4];
    logic        c_sw [0:4];
    logic [7:0]  c_dout [0:3];
    logic        c_dvo [0:3];
    logic [31:0] c_acc [0:3];
    logic        c_avo [0:3];
    logic        c_rdy [0:3];
    logic        c_ovf [0:3];

    assign c_wt[0] = col_wt;
    assign c_ld[0] = col_ld;
    assign c_sw[0] = col_sw;

    for (genvar k = 0; k < 4; k++) begin : g_col
        pe_ws_dbuf #(.DATA_W(8), .ACC_W(32), .SIGNED(1), .SAT(1)) u_cell (
            .clk(clk), .rst_n(rst_n), .data_in(col_d), .data_vld_in(col_dv),
            .data_out(c_dout[k]), .data_vld_out(c_dvo[k]), .acc_in(32'h0),
            .acc_out(c_acc[k]), .acc_vld_out(c_avo[k]), .wt_in(c_wt[k]),
            .wt_ld_in(c_ld[k]), .wt_out(c_wt[k+1]), .wt_ld_out(c_ld[k+1]),
            .swap_in(c_sw[k]), .swap_out(c_sw[k+1]), .wt_ready(c_rdy[k]),
            .ovf(c_ovf[k]), .ovf_clr(1'b0)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic        vld;
        logic [7:0]  data;
        logic [31:0] acc;
        logic        ld;
        logic [7:0]  wt;
        logic        swap;
        logic        clr;
        logic [31:0] e_s;
        logic [31:0] e_w;
        logic        e_vld;
        logic        e_ovf_s;
        logic        e_ovf_w;
        logic        e_rdy;
    } vec_t;

    function automatic vec_t mk(
        input logic vld, input logic [7:0] data, input logic [31:0] a,
        input logic l, input logic [7:0] w, input logic s, input logic c,
        input logic [31:0] es, input logic [31:0] ew, input logic ev,
        input logic eos, input logic eow, input logic er);
        vec_t v;
        v.vld = vld; v.data = data; v.acc = a; v.ld = l; v.wt = w; v.swap = s;
        v.clr = c; v.e_s = es; v.e_w = ew; v.e_vld = ev; v.e_ovf_s = eos;
        v.e_ovf_w = eow; v.e_rdy = er;
        return v;
    endfunction

    vec_t vt [0:25];
    logic [7:0] last_data;

    initial begin
        // vld data acc ld wt swap clr | acc_sat acc_wrap vld ovf_sat ovf_wrap rdy
        vt[0]  = mk(1'b0, 8'h00, 32'h00000000, 1'b1, 8'hFD, 1'b0, 1'b0, 32'h00001234, 32'h00001234, 1'b0, 1'b0, 1'b0, 1'b0);
        vt[1]  = mk(1'b0, 8'h00, 32'h00000000, 1'b0, 8'h00, 1'b1, 1'b0, 32'h00001234, 32'h00001234, 1'b0, 1'b0, 1'b0, 1'b1);
        vt[2]  = mk(1'b1, 8'h05, 32'h0000000A, 1'b0, 8'h00, 1'b0, 1'b0, 32'hFFFFFFFB, 32'hFFFFFFFB, 1'b1, 1'b0, 1'b0, 1'b1);
        vt[3]  = mk(1'b1, 8'hFC, 32'h00000000, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0000000C, 32'h0000000C, 1'b1, 1'b0, 1'b0, 1'b1);
        vt[4]  = mk(1'b0, 8'h07, 32'h00000063, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0000000C, 32'h0000000C, 1'b0, 1'b0, 1'b0, 1'b1);
        vt[5]  = mk(1'b1, 8'h7F, 32'h80000100, 1'b0, 8'h00, 1'b0, 1'b0, 32'h80000000, 32'h7FFFFF83, 1'b1, 1'b1, 1'b1, 1'b1);
        vt[6]  = mk(1'b1, 8'h00, 32'h00000005, 1'b0, 8'h00, 1'b0, 1'b1, 32'h00000005, 32'h00000005, 1'b1, 1'b0, 1'b0, 1'b1);
        vt[7]  = mk(1'b1, 8'h01, 32'h00000000, 1'b1, 8'h7F, 1'b0, 1'b0, 32'hFFFFFFFD, 32'hFFFFFFFD, 1'b1, 1'b0, 1'b0, 1'b1);
        vt[8]  = mk(1'b1, 8'h7F, 32'h7FFFFFF0, 1'b0, 8'h00, 1'b1, 1'b0, 32'h7FFFFE73, 32'h7FFFFE73, 1'b1, 1'b0, 1'b0, 1'b1);
        vt[9]  = mk(1'b1, 8'h7F, 32'h7FFFFFF0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h7FFFFFFF, 32'h80003EF1, 1'b1, 1'b1, 1'b1, 1'b1);
        vt[10] = mk(1'b1, 8'h00, 32'h00000000, 1'b0, 8'h00, 1'b0, 1'b1, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1);
        vt[11] = mk(1'b1, 8'h02, 32'h00000000, 1'b1, 8'h02, 1'b0, 1'b0, 32'h000000FE, 32'h000000FE, 1'b1, 1'b0, 1'b0, 1'b1);
        vt[12] = mk(1'b1, 8'h01, 32'h00000000, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0000007F, 32'h0000007F, 1'b1, 1'b0, 1'b0, 1'b1);
        vt[13] = mk(1'b1, 8'h01, 32'h00000064, 1'b1, 8'h09, 1'b0, 1'b0, 32'h00000066, 32'h00000066, 1'b1, 1'b0, 1'b0, 1'b1);
        vt[14] = mk(1'b1, 8'h01, 32'h00000000, 1'b0, 8'h00, 1'b1, 1'b0, 32'h00000002, 32'h00000002, 1'b1, 1'b0, 1'b0, 1'b1);
        vt[15] = mk(1'b1, 8'h01, 32'h00000000, 1'b0, 8'h00, 1'b0, 1'b0, 32'h00000009, 32'h00000009, 1'b1, 1'b0, 1'b0, 1'b1);
        vt[16] = mk(1'b1, 8'h03, 32'h00000001, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0000001C, 32'h0000001C, 1'b1, 1'b0, 1'b0, 1'b1);
        vt[17] = mk(1'b1, 8'h01, 32'h00000000, 1'b0, 8'h00, 1'b0, 1'b0, 32'h00000009, 32'h00000009, 1'b1, 1'b0, 1'b0, 1'b1);
        vt[18] = mk(1'b1, 8'h01, 32'h00000000, 1'b1, 8'h05, 1'b0, 1'b0, 32'h00000009, 32'h00000009, 1'b1, 1'b0, 1'b0, 1'b1);
        vt[19] = mk(1'b1, 8'h01, 32'h00000000, 1'b1, 8'h06, 1'b1, 1'b0, 32'h00000009, 32'h00000009, 1'b1, 1'b0, 1'b0, 1'b1);
        vt[20] = mk(1'b1, 8'h01, 32'h00000000, 1'b0, 8'h00, 1'b0, 1'b0, 32'h00000005, 32'h00000005, 1'b1, 1'b0, 1'b0, 1'b1);
        vt[21] = mk(1'b1, 8'h01, 32'h00000000, 1'b0, 8'h00, 1'b1, 1'b0, 32'h00000005, 32'h00000005, 1'b1, 1'b0, 1'b0, 1'b1);
        vt[22] = mk(1'b1, 8'h01, 32'h00000000, 1'b0, 8'h00, 1'b0, 1'b0, 32'h00000006, 32'h00000006, 1'b1, 1'b0, 1'b0, 1'b1);
        vt[23] = mk(1'b1, 8'h80, 32'h00000000, 1'b0, 8'h00, 1'b0, 1'b0, 32'hFFFFFD00, 32'hFFFFFD00, 1'b1, 1'b0, 1'b0, 1'b1);
        vt[24] = mk(1'b1, 8'h01, 32'h7FFFFFFF, 1'b0, 8'h00, 1'b0, 1'b1, 32'h7FFFFFFF, 32'h80000005, 1'b1, 1'b1, 1'b1, 1'b1);
        vt[25] = mk(1'b0, 8'h00, 32'h00000000, 1'b0, 8'h00, 1'b0, 1'b0, 32'h7FFFFFFF, 32'h80000005, 1'b0, 1'b1, 1'b1, 1'b1);

        rst_n = 1'b0;
        d = '0; dv = 1'b0; acc = '0; wt = '0; ld = 1'b0; sw = 1'b0; clr = 1'b0;
        col_wt = '0; col_ld = 1'b0; col_sw = 1'b0; col_dv = 1'b0; col_d = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Random traffic, then an asynchronous reset in the middle of a cycle.
        @(negedge clk);
        ld = 1'b1; wt = 8'($urandom); dv = 1'b1; d = 8'($urandom); acc = $urandom;
        col_ld = 1'b1; col_wt = 8'($urandom); col_dv = 1'b1; col_d = 8'($urandom);
        @(negedge clk);
        ld = 1'b0; sw = 1'b1; d = 8'($urandom); acc = $urandom;
        col_ld = 1'b0; col_sw = 1'b1;
        @(negedge clk);
        sw = 1'b1; ld = 1'b1; wt = 8'($urandom); d = 8'($urandom); acc = $urandom;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("reset_sat_outputs", 64'({dout_s, dvo_s, acco_s, avo_s, wto_s, ldo_s, swo_s, rdy_s, ovf_s}), 64'h0);
        chk("reset_wrap_outputs", 64'({dout_w, dvo_w, acco_w, avo_w, wto_w, ldo_w, swo_w, rdy_w, ovf_w}), 64'h0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("reset_col%0d_outputs", k),
                64'({c_dout[k], c_dvo[k], c_acc[k], c_avo[k], c_wt[k+1], c_ld[k+1], c_sw[k+1], c_rdy[k], c_ovf[k]}), 64'h0);
        end
        @(negedge clk);
        d = '0; dv = 1'b0; acc = '0; wt = '0; ld = 1'b0; sw = 1'b0; clr = 1'b0;
        col_wt = '0; col_ld = 1'b0; col_sw = 1'b0; col_dv = 1'b0; col_d = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // No weight committed since reset: the MAC passes acc_in straight through.
        dv = 1'b1; d = 8'h33; acc = 32'h00001234;
        @(negedge clk);
        chk("passthru_acc_sat", 64'(acco_s), 64'h1234);
        chk("passthru_acc_wrap", 64'(acco_w), 64'h1234);
        chk("passthru_vld", 64'({avo_s, dvo_s}), 64'h3);
        chk("passthru_not_ready", 64'(rdy_s), 64'h0);
        last_data = 8'h33;

        for (int i = 0; i < 26; i++) begin
            dv = vt[i].vld; d = vt[i].data; acc = vt[i].acc; ld = vt[i].ld;
            wt = vt[i].wt; sw = vt[i].swap; clr = vt[i].clr;
            if (vt[i].vld) last_data = vt[i].data;
            @(negedge clk);
            chk($sformatf("v%0d_acc_sat", i), 64'(acco_s), 64'(vt[i].e_s));
            chk($sformatf("v%0d_acc_wrap", i), 64'(acco_w), 64'(vt[i].e_w));
            chk($sformatf("v%0d_vld", i), 64'({avo_s, dvo_s, avo_w}), 64'({3{vt[i].e_vld}}));
            chk($sformatf("v%0d_ovf_sat", i), 64'(ovf_s), 64'(vt[i].e_ovf_s));
            chk($sformatf("v%0d_ovf_wrap", i), 64'(ovf_w), 64'(vt[i].e_ovf_w));
            chk($sformatf("v%0d_ready", i), 64'({rdy_s, rdy_w}), 64'({2{vt[i].e_rdy}}));
            chk($sformatf("v%0d_data_out", i), 64'(dout_s), 64'(last_data));
            chk($sformatf("v%0d_chain", i), 64'({wto_s, ldo_s, swo_s}), 64'({vt[i].wt, vt[i].ld, vt[i].swap}));
        end
        dv = 1'b0; ld = 1'b0; sw = 1'b0; clr = 1'b0; wt = '0;

        // Column: shift beats 1..4, then a swap wavefront from the top.
        // Every strobed beat passes every cell, so each shadow ends at 4.
        col_ld = 1'b1;
        for (int b = 1; b <= 4; b++) begin
            col_wt = 8'(b);
            @(negedge clk);
        end
        col_ld = 1'b0; col_wt = '0; col_sw = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            col_sw = 1'b0;
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("col_t%0d_row%0d_ready", j, k), 64'(c_rdy[k]), 64'(k <= j));
                chk($sformatf("col_t%0d_row%0d_swap_out", j, k), 64'(c_sw[k+1]), 64'(k == j));
            end
        end
        col_dv = 1'b1; col_d = 8'h01;
        @(negedge clk);
        col_dv = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("col_row%0d_active", k), 64'(c_acc[k]), 64'h4);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
